// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction port A and data port B share one memory.
// Define ARB_ROUND_ROBIN_EN for round-robin; default build always favours port B.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                read_a,
  input  logic [ADDR_W-1:0]   address_a,
  output logic                resp_a,
  output logic [DATA_W-1:0]   rdata_a,
  input  logic                read_b,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wmask,
  output logic                resp_b,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [DATA_W-1:0]   pmem_wdata,
  output logic [DATA_W/8-1:0] pmem_wmask,
  input  logic [DATA_W-1:0]   pmem_rdata,
  input  logic                pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_A,
    SERVE_B
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic                we_q;

  logic req_a;
  logic req_b;
  logic grant_b;
  logic start;

  assign req_a = read_a;
  assign req_b = read_b | write;

`ifdef ARB_ROUND_ROBIN_EN
  logic favor_b_q;

  // Pointer favours the port not served by the last completed transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      favor_b_q <= 1'b1;
    end else if (pmem_resp && state_q == SERVE_A) begin
      favor_b_q <= 1'b1;
    end else if (pmem_resp && state_q == SERVE_B) begin
      favor_b_q <= 1'b0;
    end
  end

  assign grant_b = req_b & (~req_a | favor_b_q);
`else
  assign grant_b = req_b;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: arbitrate in IDLE, return to IDLE on memory completion.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_b) begin
          state_d = SERVE_B;
          start   = 1'b1;
        end else if (req_a) begin
          state_d = SERVE_A;
          start   = 1'b1;
        end
      end
      SERVE_A,
      SERVE_B: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the granted port's request so the memory sees a stable copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      we_q    <= 1'b0;
    end else if (start) begin
      if (grant_b) begin
        addr_q  <= address_b;
        wdata_q <= wdata;
        wmask_q <= wmask;
        we_q    <= write;
      end else begin
        addr_q  <= address_a;
        wdata_q <= '0;
        wmask_q <= '0;
        we_q    <= 1'b0;
      end
    end
  end

  // Memory-side and requester-side outputs.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    resp_a       = 1'b0;
    resp_b       = 1'b0;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    pmem_wmask   = wmask_q;
    rdata_a      = pmem_rdata;
    rdata_b      = pmem_rdata;
    if (state_q != IDLE) begin
      pmem_read  = ~we_q;
      pmem_write = we_q;
    end
    if (state_q == SERVE_A) begin
      resp_a = pmem_resp;
    end
    if (state_q == SERVE_B) begin
      resp_b = pmem_resp;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard.
// Honors ARB_ROUND_ROBIN_EN for the contention expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_a = 1'b0;
  logic [31:0] address_a = '0;
  logic        resp_a;
  logic [31:0] rdata_a;
  logic        read_b = 1'b0;
  logic        write = 1'b0;
  logic [31:0] address_b = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wmask = '0;
  logic        resp_b;
  logic [31:0] rdata_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;

  typedef struct {
    bit          port_b;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .read_a(read_a),
    .address_a(address_a),
    .resp_a(resp_a),
    .rdata_a(rdata_a),
    .read_b(read_b),
    .write(write),
    .address_b(address_b),
    .wdata(wdata),
    .wmask(wmask),
    .resp_b(resp_b),
    .rdata_b(rdata_b),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_wmask(pmem_wmask),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_resp(logic [31:0] d, bit port_b, bit expect_resp);
    exp_t e;
    pmem_rdata = d;
    pmem_resp  = 1'b1;
    if (expect_resp) begin
      e.port_b = port_b;
      e.data   = d;
      sb.push_back(e);
    end
    tick();
    pmem_resp = 1'b0;
  endtask

  // Every response pulse is matched against the oldest expected one.
  always @(negedge clk) begin
    if (resp_a === 1'b1 || resp_b === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'({resp_a, resp_b}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_port", 32'({resp_a, resp_b}),
            e.port_b ? 32'd1 : 32'd2);
        chk("resp_data", e.port_b ? rdata_b : rdata_a, e.data);
      end
    end
  end

  initial begin
    bit exp_b;

    tick();
    tick();
    #3;
    chk("rst_pmem_read", 32'(pmem_read), 32'd0);
    chk("rst_pmem_write", 32'(pmem_write), 32'd0);
    chk("rst_resp_a", 32'(resp_a), 32'd0);
    chk("rst_resp_b", 32'(resp_b), 32'd0);
    chk("rst_addr", pmem_address, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    read_a    = 1'b1;
    address_a = 32'h60;
    tick();
    read_a = 1'b0;
    #3;
    chk("fetch_read", 32'(pmem_read), 32'd1);
    chk("fetch_write", 32'(pmem_write), 32'd0);
    chk("fetch_addr", pmem_address, 32'h60);
    tick();
    tick();
    pulse_resp(32'h00000013, 1'b0, 1'b1);
    #3;
    chk("fetch_done", 32'(pmem_read), 32'd0);
    tick();

    write     = 1'b1;
    address_b = 32'h100;
    wdata     = 32'hDEADBEEF;
    wmask     = 4'hF;
    tick();
    write = 1'b0;
    #3;
    chk("store_write", 32'(pmem_write), 32'd1);
    chk("store_read", 32'(pmem_read), 32'd0);
    chk("store_addr", pmem_address, 32'h100);
    chk("store_wdata", pmem_wdata, 32'hDEADBEEF);
    chk("store_wmask", 32'(pmem_wmask), 32'hF);
    tick();
    pulse_resp(32'h55AA55AA, 1'b1, 1'b1);
    #3;
    chk("store_done", 32'(pmem_write), 32'd0);
    tick();

    read_b    = 1'b1;
    write     = 1'b1;
    address_b = 32'h104;
    wdata     = 32'h12345678;
    wmask     = 4'h3;
    tick();
    read_b = 1'b0;
    write  = 1'b0;
    #3;
    chk("rw_write", 32'(pmem_write), 32'd1);
    chk("rw_read", 32'(pmem_read), 32'd0);
    chk("rw_wmask", 32'(pmem_wmask), 32'h3);
    tick();
    pulse_resp(32'hCAFEF00D, 1'b1, 1'b1);
    tick();

    read_a    = 1'b1;
    address_a = 32'h60;
    tick();
    read_a    = 1'b0;
    address_a = 32'h80;
    #3;
    chk("hold_addr0", pmem_address, 32'h60);
    tick();
    #3;
    chk("hold_addr1", pmem_address, 32'h60);
    tick();
    #3;
    chk("hold_addr2", pmem_address, 32'h60);
    pulse_resp(32'hA5A5A5A5, 1'b0, 1'b1);
    tick();

    pmem_rdata = 32'hBAD0BAD0;
    pmem_resp  = 1'b1;
    #3;
    chk("stray_resp_a", 32'(resp_a), 32'd0);
    chk("stray_resp_b", 32'(resp_b), 32'd0);
    tick();
    pmem_resp = 1'b0;
    #3;
    chk("stray_idle", 32'(pmem_read), 32'd0);
    read_a    = 1'b1;
    address_a = 32'h40;
    tick();
    read_a = 1'b0;
    #3;
    chk("stray_next_read", 32'(pmem_read), 32'd1);
    chk("stray_next_addr", pmem_address, 32'h40);
    tick();
    pulse_resp(32'h00000077, 1'b0, 1'b1);
    tick();

    read_b    = 1'b1;
    address_b = 32'h180;
    tick();
    read_b = 1'b0;
    #3;
    chk("rstsrv_read", 32'(pmem_read), 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #3;
    chk("rstsrv_read0", 32'(pmem_read), 32'd0);
    chk("rstsrv_write0", 32'(pmem_write), 32'd0);
    chk("rstsrv_addr0", pmem_address, 32'd0);
    tick();
    pmem_rdata = 32'hDEAD0001;
    pmem_resp  = 1'b1;
    #3;
    chk("rstsrv_no_resp", 32'(resp_b), 32'd0);
    tick();
    pmem_resp = 1'b0;
    #3;
    chk("rstsrv_idle", 32'(pmem_read), 32'd0);

    address_a = 32'h200;
    address_b = 32'h300;
    for (int i = 0; i < 4; i++) begin
      read_a = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      read_b = 1'b1;
      exp_b  = (i % 2) == 0;
`else
      read_b = (i < 2);
      exp_b  = (i < 2);
`endif
      tick();
      #3;
      chk($sformatf("cont_addr%0d", i), pmem_address,
          exp_b ? 32'h300 : 32'h200);
      chk($sformatf("cont_read%0d", i), 32'(pmem_read), 32'd1);
      tick();
      pulse_resp(32'h1000 + 32'(i), exp_b, 1'b1);
      #3;
      chk($sformatf("cont_gap%0d", i), 32'(pmem_read), 32'd0);
    end
    read_a = 1'b0;
    read_b = 1'b0;
    tick();
    tick();
    #3;
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
